// File: rtl/ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl
// Fetch-request sequencer for the instruction fetch unit. It owns the fetch PC,
// issues I-cache requests only when both an in-flight slot and a fetch-queue
// slot are free, tags each in-order response with {pc, predicted npc} from a
// small metadata FIFO, and pushes fetch groups into the fetch queue. After a
// redirect, responses that belong to killed requests are counted down and
// dropped (DRAIN state) before fetching resumes.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i, flush_pc_i     redirect and its target PC
//   bpu_taken_i/target_i    prediction for icache_req_pc_o, sampled on fire
//   icache_req_valid_o/ready_i/pc_o   request channel
//   icache_rsp_valid_i/data_i         in-order response channel
//   fq_push_o, fq_pc_o, fq_pred_npc_o, fq_data_o   fetch-queue push
//   fq_pop_i                downstream consumed one fetch-queue entry
//   inflight_cnt_o          outstanding requests (live + stale)
//   fq_credit_o             fetch-queue slots not yet used or reserved
//
// Handshake: a request transfers on a cycle where icache_req_valid_o and
// icache_req_ready_i are both high ("fire"); valid never depends on ready.
// Responses have no ready: every request that fired already owns a
// fetch-queue slot, so a live response is pushed in the cycle it arrives.
// -----------------------------------------------------------------------------
module ifu_fetch_ctrl #(
   parameter int              XLEN            = 32,
   parameter int              INSTR_PER_FETCH = 4,
   parameter int              IFU_INF_DEPTH   = 2,
   parameter int              IFU_FQ_DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     flush_i,
   input  logic [XLEN-1:0]                          flush_pc_i,
   input  logic                                     bpu_taken_i,
   input  logic [XLEN-1:0]                          bpu_target_i,
   output logic                                     icache_req_valid_o,
   input  logic                                     icache_req_ready_i,
   output logic [XLEN-1:0]                          icache_req_pc_o,
   input  logic                                     icache_rsp_valid_i,
   input  logic [32*INSTR_PER_FETCH-1:0]            icache_rsp_data_i,
   output logic                                     fq_push_o,
   output logic [XLEN-1:0]                          fq_pc_o,
   output logic [XLEN-1:0]                          fq_pred_npc_o,
   output logic [32*INSTR_PER_FETCH-1:0]            fq_data_o,
   input  logic                                     fq_pop_i,
   output logic [$clog2(IFU_INF_DEPTH+1)-1:0]       inflight_cnt_o,
   output logic [$clog2(IFU_FQ_DEPTH+1)-1:0]        fq_credit_o
);

   localparam int FB = 4 * INSTR_PER_FETCH;
   localparam int IW = $clog2(IFU_INF_DEPTH + 1);
   localparam int QW = $clog2(IFU_FQ_DEPTH + 1);
   localparam int PW = (IFU_INF_DEPTH > 1) ? $clog2(IFU_INF_DEPTH) : 1;
   localparam logic [XLEN-1:0] FB_MASK = XLEN'(FB - 1);
   localparam logic [XLEN-1:0] FB_STEP = XLEN'(FB);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic [IW-1:0]     inflight;
   logic [IW-1:0]     drop_cnt;
   logic [QW-1:0]     fq_cnt;
   logic [XLEN-1:0]   meta_pc  [IFU_INF_DEPTH];
   logic [XLEN-1:0]   meta_npc [IFU_INF_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic [IW-1:0]     live_inflight;
   logic [IW-1:0]     stale_left;
   logic              rsp_ok;
   logic              pop_ok;
   logic              room_ok;
   logic              req_valid;
   logic              fire;
   logic              push;
   logic [XLEN-1:0]   seq_pc;
   logic [XLEN-1:0]   npc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(IFU_INF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Stale requests still occupy the I-cache but no longer hold a queue slot.
   assign live_inflight = inflight - drop_cnt;
   // Requests that will still be outstanding once this cycle's response lands;
   // on a flush these are exactly the responses to be discarded.
   assign stale_left    = inflight - IW'(rsp_ok);

   // Illegal events (response with nothing outstanding, pop of an empty
   // queue) are ignored rather than allowed to wrap the counters.
   assign rsp_ok  = icache_rsp_valid_i && (inflight != '0);
   assign pop_ok  = fq_pop_i && (fq_cnt != '0) && !flush_i;
   assign room_ok = (int'(live_inflight) < IFU_INF_DEPTH) &&
                    (int'(fq_cnt) + int'(live_inflight) < IFU_FQ_DEPTH);

   assign req_valid = !rst_i && (state == ST_RUN) && !flush_i && room_ok;
   assign fire      = req_valid && icache_req_ready_i;
   // A response in a flush cycle belongs to a killed request.
   assign push      = !rst_i && rsp_ok && (drop_cnt == '0) && !flush_i;

   // Next sequential group starts at the following FB-aligned address.
   assign seq_pc = (pc & ~FB_MASK) + FB_STEP;
   assign npc    = bpu_taken_i ? bpu_target_i : seq_pc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_RUN;
         pc       <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         fq_cnt   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         for (int i = 0; i < IFU_INF_DEPTH; i++) begin
            meta_pc[i]  <= '0;
            meta_npc[i] <= '0;
         end
      end else begin
         inflight <= inflight + IW'(fire) - IW'(rsp_ok);
         if (flush_i) begin
            pc       <= flush_pc_i;
            fq_cnt   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= stale_left;
            state    <= (stale_left != '0) ? ST_DRAIN : ST_RUN;
         end else begin
            fq_cnt <= fq_cnt + QW'(push) - QW'(pop_ok);
            if (fire) begin
               meta_pc[wr_ptr]  <= pc;
               meta_npc[wr_ptr] <= npc;
               wr_ptr           <= ptr_inc(wr_ptr);
               pc               <= npc;
            end
            if (push) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
            if (rsp_ok && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - IW'(1);
               if (drop_cnt == IW'(1)) begin
                  state <= ST_RUN;
               end
            end
         end
      end
   end

   assign icache_req_valid_o = req_valid;
   assign icache_req_pc_o    = pc;
   assign fq_push_o          = push;
   assign fq_pc_o            = push ? meta_pc[rd_ptr]  : '0;
   assign fq_pred_npc_o      = push ? meta_npc[rd_ptr] : '0;
   assign fq_data_o          = push ? icache_rsp_data_i : '0;
   assign inflight_cnt_o     = inflight;
   assign fq_credit_o        = rst_i ? '0 :
                               QW'(IFU_FQ_DEPTH) - fq_cnt - QW'(live_inflight);

   a_rsp_with_nothing_outstanding: assert property (
      @(posedge clk_i) disable iff (rst_i)
      !(icache_rsp_valid_i && (inflight == '0)));

   a_pop_of_empty_queue: assert property (
      @(posedge clk_i) disable iff (rst_i)
      !(fq_pop_i && (fq_cnt == '0)));

   a_queue_space_reserved: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (int'(fq_cnt) + int'(inflight) <= IFU_FQ_DEPTH + int'(drop_cnt)));

endmodule
